// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss, memory-return and data/tag-array signals of the cache fill handler
// master: cache pipeline + memory side (drives miss and returned data)
// slave: fill FSM (drives busy, memory request, array write controls)
// FILL_MISS_CNT_EN adds miss_count driven by the slave
interface cache_fill_fsm_if #(parameter int ADDR_W = 16, parameter int WORDS = 8);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic [15:0]       memory_data;
    logic              fsm_busy;
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic [ADDR_W-1:0] fill_address;
    logic [WORDS-1:0]  word_enable;
    logic              write_data_array;
    logic              write_tag_array;
    logic [15:0]       fill_data;
`ifdef FILL_MISS_CNT_EN
    logic [15:0]       miss_count;
    modport master(output miss_detected, miss_address, memory_data_valid, memory_data,
                   input fsm_busy, mem_read_en, memory_address, fill_address, word_enable,
                   write_data_array, write_tag_array, fill_data, miss_count);
    modport slave(input miss_detected, miss_address, memory_data_valid, memory_data,
                  output fsm_busy, mem_read_en, memory_address, fill_address, word_enable,
                  write_data_array, write_tag_array, fill_data, miss_count);
`else
    modport master(output miss_detected, miss_address, memory_data_valid, memory_data,
                   input fsm_busy, mem_read_en, memory_address, fill_address, word_enable,
                   write_data_array, write_tag_array, fill_data);
    modport slave(input miss_detected, miss_address, memory_data_valid, memory_data,
                  output fsm_busy, mem_read_en, memory_address, fill_address, word_enable,
                  write_data_array, write_tag_array, fill_data);
`endif
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: L1 miss handler issuing a pipelined block read and writing returned words into the arrays
// clk, rst_n: clock and synchronous active-low reset
// bus (slave): miss_detected/miss_address in; memory_data_valid/memory_data in;
//   fsm_busy, mem_read_en, memory_address, fill_address, word_enable,
//   write_data_array, write_tag_array, fill_data out
// FILL_MISS_CNT_EN adds bus.miss_count, counting accepted misses
module cache_fill_fsm #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
) (
    input logic             clk,
    input logic             rst_n,
    cache_fill_fsm_if.slave bus
);
    localparam int WI = $clog2(WORDS);
    localparam int BW = ADDR_W - WI - 1;
    typedef enum logic {IDLE, FILL} state_t;
    state_t        state;
    logic [BW-1:0] blk;
    logic [WI:0]   req_cnt;
    logic [WI-1:0] data_cnt;
    logic          busy;
    logic          req_open;
    logic          wr;
    logic          last;
    logic          unused_low;
    assign busy     = state == FILL;
    assign req_open = req_cnt != (WI+1)'(WORDS);
    assign wr       = busy & bus.memory_data_valid;
    assign last     = wr & (data_cnt == WI'(WORDS-1));
    assign unused_low = &{1'b0, bus.miss_address[WI:0]};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            blk      <= '0;
            req_cnt  <= '0;
            data_cnt <= '0;
        end else if (!busy) begin
            if (bus.miss_detected) begin
                state    <= FILL;
                blk      <= bus.miss_address[ADDR_W-1:WI+1];
                req_cnt  <= '0;
                data_cnt <= '0;
            end
        end else begin
            if (req_open) req_cnt <= req_cnt + 1'b1;
            if (wr) data_cnt <= data_cnt + 1'b1;
            if (last) state <= IDLE;
        end
    end
`ifdef FILL_MISS_CNT_EN
    logic [15:0] miss_count;
    always_ff @(posedge clk) begin
        if (!rst_n) miss_count <= '0;
        else if (!busy && bus.miss_detected) miss_count <= miss_count + 1'b1;
    end
    assign bus.miss_count = miss_count;
`endif
    // once all requests are out req_cnt parks at WORDS, so pin the index to the last word to hold the address
    assign bus.fsm_busy         = busy;
    assign bus.mem_read_en      = busy & req_open;
    assign bus.memory_address   = {blk, req_open ? req_cnt[WI-1:0] : WI'(WORDS-1), 1'b0};
    assign bus.fill_address     = {blk, data_cnt, 1'b0};
    assign bus.word_enable      = WORDS'(1) << data_cnt;
    assign bus.write_data_array = wr;
    assign bus.write_tag_array  = last;
    assign bus.fill_data        = busy ? bus.memory_data : 16'h0000;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized bench for cache_fill_fsm against a block-fill reference model and a 4-cycle memory model
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    cache_fill_fsm_if bus();
    cache_fill_fsm dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {logic [15:0] a; int t;} req_t;
    req_t        memq[$];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gap_len = 0;
    int          gap_left = 0;
    int          stall_pct = 0;
    bit          force_valid = 0;
    bit          m_busy = 0;
    logic [11:0] m_blk = '0;
    int          m_req = 0;
    int          m_wr = 0;
    logic [15:0] m_cnt = '0;
    int          busy_seen = 0;
    int          wr_seen = 0;
    int          tag_seen = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    function automatic logic [15:0] mdata(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction
    // check this cycle against the model, advance the model across the edge, then drive memory returns
    task automatic tick();
        bit exp_rd;
        bit exp_wr;
        logic [15:0] word_addr;
        #1;
        exp_rd = m_busy && m_req < 8;
        exp_wr = m_busy && bus.memory_data_valid;
        word_addr = {m_blk, 3'(m_wr), 1'b0};
        check("busy", bus.fsm_busy, m_busy);
        check("rd_en", bus.mem_read_en, exp_rd);
        if (exp_rd) check("mem_addr", bus.memory_address, {m_blk, 3'(m_req), 1'b0});
        check("wr_data", bus.write_data_array, exp_wr);
        check("wr_tag", bus.write_tag_array, exp_wr && m_wr == 7);
        if (exp_wr) begin
            check("fill_addr", bus.fill_address, word_addr);
            check("word_en", bus.word_enable, 8'b1 << m_wr);
            check("fill_data", bus.fill_data, mdata(word_addr));
        end
`ifdef FILL_MISS_CNT_EN
        check("miss_cnt", bus.miss_count, m_cnt);
`endif
        busy_seen += int'(bus.fsm_busy);
        wr_seen += int'(bus.write_data_array);
        tag_seen += int'(bus.write_tag_array);
        if (bus.mem_read_en) memq.push_back('{bus.memory_address, cyc + 4});
        if (!rst_n) begin
            m_busy = 0; m_blk = '0; m_req = 0; m_wr = 0; m_cnt = '0;
            memq.delete();
            gap_left = 0;
        end else if (!m_busy) begin
            if (bus.miss_detected) begin
                m_busy = 1; m_blk = bus.miss_address[15:4]; m_req = 0; m_wr = 0; m_cnt++;
            end
        end else begin
            if (m_req < 8) m_req++;
            if (bus.memory_data_valid) begin
                if (m_wr == 7) m_busy = 0;
                m_wr++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (force_valid) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data = 16'($urandom);
        end else if (memq.size() > 0 && memq[0].t <= cyc && gap_left == 0 && $urandom_range(99) >= stall_pct) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data = mdata(memq[0].a);
            void'(memq.pop_front());
            gap_left = gap_len;
        end else begin
            bus.memory_data_valid = 1'b0;
            bus.memory_data = 16'($urandom);
            if (gap_left > 0) gap_left--;
        end
    endtask
    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            tick();
            n++;
        end
        if (m_busy) check("idle_timeout", 1, 0);
    endtask
    task automatic fill(input logic [15:0] a);
        bus.miss_detected = 1'b1;
        bus.miss_address = a;
        tick();
        bus.miss_detected = 1'b0;
        wait_idle(200);
    endtask
    initial begin
        bus.miss_detected = 1'b0;
        bus.miss_address = '0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data = '0;
        @(posedge clk);
        #1;
        check("rst_busy", bus.fsm_busy, 0);
        check("rst_rd_en", bus.mem_read_en, 0);
        check("rst_mem_addr", bus.memory_address, 0);
        check("rst_fill_addr", bus.fill_address, 0);
        check("rst_word_en", bus.word_enable, 8'h01);
        check("rst_wr_data", bus.write_data_array, 0);
        check("rst_wr_tag", bus.write_tag_array, 0);
        check("rst_fill_data", bus.fill_data, 0);
        rst_n = 1'b1;
        tick();
        bus.miss_detected = 1'b1;
        bus.miss_address = 16'h1234;
        tick();
        bus.miss_detected = 1'b0;
        busy_seen = 0; wr_seen = 0; tag_seen = 0;
        repeat (14) tick();
        check("basic_busy_len", busy_seen, 12);
        check("basic_writes", wr_seen, 8);
        check("basic_tags", tag_seen, 1);
        gap_len = 3;
        wr_seen = 0; tag_seen = 0;
        fill(16'h5678);
        check("stall_writes", wr_seen, 8);
        check("stall_tags", tag_seen, 1);
        gap_len = 0;
        bus.miss_detected = 1'b1;
        bus.miss_address = 16'h1234;
        tick();
        bus.miss_detected = 1'b0;
        repeat (4) tick();
        bus.miss_detected = 1'b1;
        bus.miss_address = 16'hABCD;
        wait_idle(100);
        check("hold_blk", m_blk, 12'h123);
        tick();
        bus.miss_detected = 1'b0;
        check("refetch_blk", m_blk, 12'hABC);
        wait_idle(100);
        force_valid = 1;
        tick();
        tick();
        force_valid = 0;
        fill(16'h0F00);
        bus.miss_detected = 1'b1;
        bus.miss_address = 16'h2468;
        tick();
        bus.miss_detected = 1'b0;
        for (int n = 0; n < 50 && m_wr < 3; n++) tick();
        check("pre_rst_words", m_wr, 3);
        rst_n = 1'b0;
        force_valid = 1;
        tick();
        rst_n = 1'b1;
        force_valid = 0;
        wr_seen = 0;
        tick();
        check("post_rst_writes", wr_seen, 0);
        fill(16'h0040);
`ifdef FILL_MISS_CNT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) fill(16'($urandom));
        #1;
        check("miss_count_3", bus.miss_count, 16'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("miss_count_rst", bus.miss_count, 16'd0);
`endif
        stall_pct = 30;
        repeat (400) begin
            bus.miss_detected = ($urandom_range(3) == 0);
            bus.miss_address = 16'($urandom);
            tick();
        end
        bus.miss_detected = 1'b0;
        wait_idle(200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
